// File: rtl/pool_ctrl.sv
// Input-side controller for the max-pool stage: accepts a raster pixel stream,
// writes each pixel to the window buffers and strobes the pool function per complete window.
module pool_ctrl #(
  parameter int input_channels = 16,
  parameter int img_width      = 8,
  parameter int img_height     = 8,
  parameter int kernel_dim     = 2,
  parameter int datatype_size  = 2
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           i_start,
  input  logic                                           i_data_valid,
  output logic                                           o_data_ready,
  input  logic [input_channels-1:0][datatype_size-1:0]   i_data,
  output logic [input_channels-1:0]                      o_ibuf_we,
  output logic [input_channels-1:0][datatype_size-1:0]   o_ibuf_wr_data,
  output logic                                           o_func_start,
  input  logic                                           i_next_busy,
  output logic                                           o_busy,
  output logic                                           o_done,
  output logic [2:0]                                     dbg_state
);

  // Handshake: a pixel transfers on a rising edge where i_data_valid and o_data_ready
  // are both 1; o_data_ready never depends on i_data_valid.

  localparam int CW        = (img_width  > 1) ? $clog2(img_width)  : 1;
  localparam int RW        = (img_height > 1) ? $clog2(img_height) : 1;
  localparam int COL_LIMIT = (img_width  / kernel_dim) * kernel_dim;
  localparam int ROW_LIMIT = (img_height / kernel_dim) * kernel_dim;

  typedef enum logic [2:0] {IDLE, STREAM, WRITE, ISSUE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          pend_last;
  logic          col_end;
  logic          row_end;
  logic          win_done;

  assign col_end  = (col == CW'(img_width - 1));
  assign row_end  = (row == RW'(img_height - 1));
  // Trailing partial columns/rows fail the limit test and never complete a window.
  assign win_done = ((int'(col) % kernel_dim) == kernel_dim - 1) &&
                    ((int'(row) % kernel_dim) == kernel_dim - 1) &&
                    (int'(col) < COL_LIMIT) && (int'(row) < ROW_LIMIT);

  // Combinational so the strobe lands in the very cycle the downstream stage frees up.
  assign o_func_start = (state == ISSUE) && !i_next_busy;
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      col            <= '0;
      row            <= '0;
      pend_last      <= 1'b0;
      o_data_ready   <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_ibuf_we      <= '0;
      o_ibuf_wr_data <= '0;
    end else begin
      o_done    <= 1'b0;
      o_ibuf_we <= '0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state        <= STREAM;
            col          <= '0;
            row          <= '0;
            o_data_ready <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        STREAM: begin
          if (i_data_valid) begin
            state          <= WRITE;
            o_ibuf_wr_data <= i_data;
            o_ibuf_we      <= '1;
            o_data_ready   <= 1'b0;
          end
        end
        WRITE: begin
          pend_last <= col_end && row_end;
          if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
          if (win_done) begin
            state <= ISSUE;
          end else if (col_end && row_end) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            state        <= STREAM;
            o_data_ready <= 1'b1;
          end
        end
        ISSUE: begin
          if (!i_next_busy) begin
            if (pend_last) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state        <= STREAM;
              o_data_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          o_data_ready <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_ctrl.sv
// Bench for pool_ctrl: directed frames plus randomized frames on a 4x4 and a 5x5 instance,
// checked cycle by cycle against a frame-arithmetic reference model.
module tb_pool_ctrl;

  localparam int CH = 16;
  localparam int DS = 2;
  localparam int N  = 2;
  localparam int DW = CH * DS;

  logic clk = 1'b0;
  logic rst, start4, start5, valid, nbusy;
  logic [CH-1:0][DS-1:0] data;

  logic ready4, ready5, fs4, fs5, busy4, busy5, done4, done5;
  logic [CH-1:0] we4, we5;
  logic [CH-1:0][DS-1:0] wd4, wd5;
  logic [2:0] st4, st5;

  always #5 clk = ~clk;

  pool_ctrl #(.input_channels(CH), .img_width(4), .img_height(4), .kernel_dim(N), .datatype_size(DS)) u_dut4 (
    .clk(clk), .rst(rst), .i_start(start4), .i_data_valid(valid), .o_data_ready(ready4),
    .i_data(data), .o_ibuf_we(we4), .o_ibuf_wr_data(wd4), .o_func_start(fs4),
    .i_next_busy(nbusy), .o_busy(busy4), .o_done(done4), .dbg_state(st4));

  pool_ctrl #(.input_channels(CH), .img_width(5), .img_height(5), .kernel_dim(N), .datatype_size(DS)) u_dut5 (
    .clk(clk), .rst(rst), .i_start(start5), .i_data_valid(valid), .o_data_ready(ready5),
    .i_data(data), .o_ibuf_we(we5), .o_ibuf_wr_data(wd5), .o_func_start(fs5),
    .i_next_busy(nbusy), .o_busy(busy5), .o_done(done5), .dbg_state(st5));

  int sel;
  logic c_ready, c_fs, c_busy, c_done;
  logic [CH-1:0] c_we;
  logic [DW-1:0] c_wd;

  always_comb begin
    c_ready = ready4; c_fs = fs4; c_busy = busy4; c_done = done4; c_we = we4; c_wd = wd4;
    if (sel == 1) begin
      c_ready = ready5; c_fs = fs5; c_busy = busy5; c_done = done5; c_we = we5; c_wd = wd5;
    end
  end

  int n_vec = 0;
  int n_fail = 0;

  // Reference model: tracks the frame in terms of accepted-pixel index and cycles since accept.
  bit m_act, m_owed, m_done_now;
  int m_k, m_since, m_last, fw, fh;
  logic [DW-1:0] exp_q[$];
  int obs_we;
  int obs_pulse[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit is_win(int idx);
    int c, r;
    c = idx % fw;
    r = idx / fw;
    return (r % N == N - 1) && (c % N == N - 1) && (c < (fw / N) * N) && (r < (fh / N) * N);
  endfunction

  function automatic bit exp_ready();
    return m_act && !m_done_now && !m_owed && (m_k < fw * fh) && (m_since == 0 || m_since >= 2);
  endfunction

  function automatic logic [DW-1:0] pix_pat(int k);
    logic [DS-1:0] v;
    v = DS'(k % 4);
    return {CH{v}};
  endfunction

  task automatic model_reset();
    m_act = 0; m_owed = 0; m_done_now = 0; m_k = 0; m_since = 0; m_last = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(bit st, bit v, bit b, logic [DW-1:0] d);
    bit acc;
    acc = exp_ready() && v;
    if (!m_act) begin
      if (st) begin
        m_act = 1; m_k = 0; m_since = 0; m_owed = 0; m_done_now = 0;
      end
    end else if (m_done_now) begin
      m_act = 0; m_done_now = 0;
    end else begin
      if (m_owed) begin
        if (!b) begin
          m_owed = 0;
          if (m_last == fw * fh - 1) m_done_now = 1;
        end
      end else if (m_since == 1) begin
        if (is_win(m_last)) m_owed = 1;
        else if (m_last == fw * fh - 1) m_done_now = 1;
      end
      if (acc) begin
        exp_q.push_back(d);
        m_last = m_k;
        m_k++;
        m_since = 1;
      end else if (m_since > 0) begin
        m_since++;
      end
    end
  endtask

  task automatic check_outputs();
    bit ew;
    ew = (m_since == 1) && m_act;
    chk("ready", DW'(c_ready), DW'(exp_ready()));
    chk("ibuf_we", DW'(c_we), DW'({CH{ew}}));
    chk("func_start", DW'(c_fs), DW'(m_owed && !nbusy));
    chk("busy", DW'(c_busy), DW'(m_act));
    chk("done", DW'(c_done), DW'(m_done_now));
    if (ew && exp_q.size() > 0) chk("wr_data", c_wd, exp_q.pop_front());
    if (c_we == '1) obs_we++;
    if (c_fs) obs_pulse.push_back(obs_we - 1);
  endtask

  task automatic step(bit st, bit v, bit b, logic [DW-1:0] d);
    start4 = (sel == 0) ? st : 1'b0;
    start5 = (sel == 1) ? st : 1'b0;
    valid = v; nbusy = b; data = d;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(st, v, b, d);
    #1;
  endtask

  task automatic reset_mid();
    rst = 1'b1; start4 = 0; start5 = 0; valid = 0; nbusy = 0;
    #1;
    chk("rst_ready", DW'(c_ready), '0);
    chk("rst_we", DW'(c_we), '0);
    chk("rst_wr_data", c_wd, '0);
    chk("rst_func_start", DW'(c_fs), '0);
    chk("rst_busy", DW'(c_busy), '0);
    chk("rst_done", DW'(c_done), '0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // vmode: 0 valid held, 1 toggled, 2 random. bmode: 0 never busy, 1 five-cycle stall, 2 random.
  task automatic run_frame(int which, int vmode, int bmode, bit spam, int rst_at, bit chk_p);
    int steps, stall;
    bit stalled, v, b, st;
    logic [DW-1:0] d;
    int exp_p[4];
    sel = which; fw = (which == 1) ? 5 : 4; fh = fw;
    if (which == 1) exp_p = '{6, 8, 16, 18};
    else            exp_p = '{5, 7, 13, 15};
    obs_we = 0; obs_pulse.delete();
    step(1, 0, 0, '0);
    steps = 0; stall = 0; stalled = 0;
    while (m_act && steps < 500) begin
      if (rst_at >= 0 && m_k == rst_at && exp_ready()) begin
        reset_mid();
        step(0, 0, 0, '0);
        return;
      end
      case (vmode)
        0: v = 1;
        1: v = (steps % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      b = 0;
      if (bmode == 1) begin
        if (m_owed && !stalled) begin stall = 5; stalled = 1; end
        b = (stall > 0);
        if (stall > 0) stall--;
      end else if (bmode == 2) begin
        b = ($urandom_range(0, 3) == 0);
      end
      d = (vmode == 2) ? DW'($urandom) : pix_pat(m_k);
      st = spam && ($urandom_range(0, 2) == 0);
      step(st, v, b, d);
      steps++;
    end
    chk("frame_timeout", DW'(steps < 500), DW'(1));
    if (chk_p) begin
      chk("we_count", DW'(obs_we), DW'(fw * fh));
      chk("pulse_count", DW'(obs_pulse.size()), DW'(4));
      for (int i = 0; i < 4; i++)
        if (i < obs_pulse.size()) chk("pulse_idx", DW'(obs_pulse[i]), DW'(exp_p[i]));
    end
    step(0, 0, 0, '0);
  endtask

  initial begin
    sel = 0; fw = 4; fh = 4;
    rst = 1'b1; start4 = 0; start5 = 0; valid = 0; nbusy = 0; data = '0;
    model_reset();
    #2;
    chk("reset_ready4", DW'(ready4), '0);
    chk("reset_we4", DW'(we4), '0);
    chk("reset_wr_data4", DW'(wd4), '0);
    chk("reset_func_start4", DW'(fs4), '0);
    chk("reset_busy4", DW'(busy4), '0);
    chk("reset_done4", DW'(done4), '0);
    chk("reset_busy5", DW'(busy5), '0);
    chk("reset_we5", DW'(we5), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 0, '0);

    run_frame(0, 0, 0, 0, -1, 1);   // 4x4, valid held, no backpressure
    run_frame(0, 0, 1, 0, -1, 1);   // five-cycle stall at the first window
    run_frame(1, 0, 0, 0, -1, 1);   // 5x5 with trailing column/row
    run_frame(0, 1, 0, 0, -1, 1);   // valid toggling 1-0-1
    run_frame(0, 0, 0, 0, 6, 0);    // reset after six accepts
    run_frame(0, 0, 0, 0, -1, 1);   // clean frame after the reset
    run_frame(0, 0, 0, 1, -1, 1);   // i_start spammed mid-frame
    for (int i = 0; i < 8; i++)
      run_frame(i % 2, 2, 2, 1'($urandom_range(0, 1)), -1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_ctrl.md
Name: pool_ctrl

Overview:
Input-side controller for the max-pool stage. It accepts a raster-order pixel stream (all channels in parallel) with a valid/ready handshake and drives the per-channel window-buffer write ports. It tracks row/column position and pulses a start strobe to the pool function whenever a complete non-overlapping kernel_dim x kernel_dim window (stride = kernel_dim) is resident. It stalls the stream while the downstream stage is busy, so a pending window is never overwritten.

Parameters:
input_channels, 16, number of parallel channels per pixel
img_width, 8, pixels per row (>= kernel_dim)
img_height, 8, rows per frame (>= kernel_dim)
kernel_dim, 2, pool window side N; stride is also N
datatype_size, 2, bits per channel value

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-high
i_start  input  1  single-cycle pulse: begin a frame
i_data_valid  input  1  upstream pixel valid
o_data_ready  output  1  controller accepts pixel this cycle
i_data  input  [datatype_size-1:0] x [input_channels-1:0]  pixel, one value per channel
o_ibuf_we  output  1 x [input_channels-1:0]  window-buffer write enable per channel
o_ibuf_wr_data  output  [datatype_size-1:0] x [input_channels-1:0]  window-buffer write data
o_func_start  output  1  single-cycle pulse: complete window ready for pool function
i_next_busy  input  1  downstream pool/next stage cannot take a window
o_busy  output  1  frame in progress
o_done  output  1  single-cycle pulse after the last window is issued, or at end of frame if none is pending

Behaviour:
- Reset: asynchronous, active-high. All outputs 0 (o_ibuf_we all 0, o_ibuf_wr_data all 0). FSM returns to IDLE; col/row counters and pending flag are cleared. Reset mid-frame abandons the frame; no o_done is issued.
- FSM states: IDLE, STREAM, WRITE, ISSUE, DONE.
- IDLE:
  - o_data_ready=0, o_busy=0.
  - i_start -> STREAM, with col=0 and row=0.
- STREAM:
  - o_data_ready=1, o_busy=1.
  - Accept occurs when i_data_valid & o_data_ready. On accept, i_data is registered -> WRITE.
- WRITE (one cycle):
  - o_ibuf_we = all 1, o_ibuf_wr_data = the registered pixel. Latency is exactly 1 cycle from the accept edge.
  - Window-complete test on the written pixel's position: (row mod N == N-1) and (col mod N == N-1) and col < (img_width/N)*N and row < (img_height/N)*N, using integer division.
  - If the window is complete -> ISSUE.
  - Else if the pixel is the last one (col==img_width-1 and row==img_height-1) -> DONE.
  - Else -> STREAM.
  - Counter update in the same cycle: col increments; it wraps to 0 at img_width-1, and on wrap row increments.
- ISSUE:
  - o_data_ready=0.
  - If !i_next_busy: o_func_start=1 for this cycle only. Then -> DONE if the pixel was the last, else -> STREAM.
  - If i_next_busy: hold in ISSUE and keep o_func_start=0 until busy deasserts. There is no time limit on the stall.
  - o_func_start therefore fires at the earliest 2 cycles after the accept edge.
- DONE: o_done=1 for one cycle -> IDLE.
- Throughput: at most one pixel per 2 cycles (STREAM/WRITE alternate). 3 cycles per pixel on window pixels when i_next_busy=0.
- i_start outside IDLE is ignored.
- Windows issued per frame = (img_width/N)*(img_height/N).
  - Trailing partial columns and rows are consumed: they are written to the buffer and counted, but never trigger a window.
- Counter widths are $clog2(img_width) and $clog2(img_height), with a minimum of 1 bit.
- i_data is sampled only on the accept edge. Its value when not accepted is don't-care.

Test Plan:
- 4x4 frame, N=2, valid held high, i_next_busy=0, pixel k has every channel = k mod 4.
  - Exactly 4 o_func_start pulses, after accepts of raster indices 5, 7, 13, 15, each 2 cycles after its accept.
  - o_done is 1 cycle after the last pulse, and 16 o_ibuf_we pulses occur.
- Same frame with i_next_busy=1 for 5 cycles starting at the first window.
  - o_data_ready stays 0 and o_func_start stays 0 throughout.
  - The pulse appears the cycle busy drops, and no o_ibuf_we fires during the stall.
- 5x5 frame, N=2: windows after raster indices 6, 8, 16, 18 only.
  - Column 4 and row 4 produce no pulses.
  - o_done follows accept of index 24 (WRITE -> DONE).
- i_data_valid toggled 1-0-1 on a 4x4 frame: the pulse pattern is identical to the first test.
  - Each o_ibuf_wr_data matches the corresponding accepted pixel 1 cycle after its accept.
- rst asserted mid-frame after 6 accepts:
  - All outputs go to 0 immediately, with no o_done.
  - A new i_start produces a full correct 4-window frame.
- i_start pulsed during STREAM: ignored, and the counters continue unchanged.
